vga_tile_buffer: RTL and testbench

Parametrised character-tile screen buffer for the VGA text path, sitting between the AXI-lite register slave and the pixel/font pipeline. It stores packed character codes, several per memory word, and serves one display read port and one AXI read port. Hardware vertical scroll uses a circular row offset. A sequential clear engine blanks one row on scroll, or the whole screen on request.

---
 rtl/vga_tile_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_tile_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_buffer.sv
// ---------------------------------------------------------------------------
// vga_tile_buffer
//
// Character-tile screen buffer for the VGA text path. Character codes are
// packed CHARS_PER_WORD to a memory word. Three logical ports (AXI write,
// AXI read, display read) address the buffer by (row, word-column). Logical
// rows are rotated by a circular base offset that implements hardware
// vertical scroll. A sequential clear engine blanks the newly exposed bottom
// row on scroll, or the whole screen on request.
//
// State table
//   state   | meaning
//   IDLE    | no clear in progress, AXI writes accepted
//   CLR_ROW | blanking one physical row, one word per cycle
//   CLR_ALL | blanking the whole memory, one word per cycle
//
// Ports
//   clk_i          pixel clock
//   rst_i          synchronous active-high reset (memory is not cleared)
//   wr_en_i        AXI write enable
//   w_row_i        logical write row
//   w_col_i        write word-column
//   w_strb_i       per-character write strobe
//   din_i          packed write data
//   r_req_i        AXI read enable
//   r_row_i        logical AXI read row
//   r_col_i        AXI read word-column
//   r_data_o       AXI read data, 1-cycle latency, held when r_req_i = 0
//   vr_row_i       logical display read row
//   vr_col_i       display read word-column
//   dout_o         display read data, 1-cycle latency, every cycle
//   scroll_i       pulse: scroll up one row
//   clr_req_i      pulse: clear whole screen
//   busy_o         clear engine active
//   scroll_row_o   current physical row offset (base)
// ---------------------------------------------------------------------------
module vga_tile_buffer #(
  parameter int H_TILES        = 80,
  parameter int V_TILES        = 30,
  parameter int CHAR_WIDTH     = 7,
  parameter int CHARS_PER_WORD = 4,
  parameter int WORDS_PER_ROW  = H_TILES / CHARS_PER_WORD,
  parameter int DATA_WIDTH     = CHAR_WIDTH * CHARS_PER_WORD,
  parameter int NUM_WORDS      = WORDS_PER_ROW * V_TILES,
  parameter int ROW_WIDTH      = 5,
  parameter int COL_WIDTH      = 5,
  parameter int ADDR_WIDTH     = 10,
  parameter logic [CHAR_WIDTH-1:0] CLEAR_CHAR = 7'h20
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [ROW_WIDTH-1:0]      w_row_i,
  input  logic [COL_WIDTH-1:0]      w_col_i,
  input  logic [CHARS_PER_WORD-1:0] w_strb_i,
  input  logic [DATA_WIDTH-1:0]     din_i,
  input  logic                      r_req_i,
  input  logic [ROW_WIDTH-1:0]      r_row_i,
  input  logic [COL_WIDTH-1:0]      r_col_i,
  output logic [DATA_WIDTH-1:0]     r_data_o,
  input  logic [ROW_WIDTH-1:0]      vr_row_i,
  input  logic [COL_WIDTH-1:0]      vr_col_i,
  output logic [DATA_WIDTH-1:0]     dout_o,
  input  logic                      scroll_i,
  input  logic                      clr_req_i,
  output logic                      busy_o,
  output logic [ROW_WIDTH-1:0]      scroll_row_o
);

  localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = {CHARS_PER_WORD{CLEAR_CHAR}};
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW   = ROW_WIDTH'(V_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST_W = ADDR_WIDTH'(WORDS_PER_ROW - 1);
  localparam logic [ADDR_WIDTH-1:0] ALL_LAST_W = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  state_t                  state;
  logic [ROW_WIDTH-1:0]    base;
  logic [ROW_WIDTH-1:0]    clr_row;
  logic [ADDR_WIDTH-1:0]   cnt;

  logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];

  // Logical (row, col) to physical word address. The top bit of the result
  // flags an in-range position. Because row < V_TILES and base < V_TILES, the
  // sum is below 2*V_TILES, so one conditional subtract replaces the modulo.
  function automatic logic [ADDR_WIDTH:0] map_addr(
    input logic [ROW_WIDTH-1:0] row,
    input logic [COL_WIDTH-1:0] col,
    input logic [ROW_WIDTH-1:0] b
  );
    logic [ROW_WIDTH:0]    sum;
    logic [ROW_WIDTH:0]    prow;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ok;
    sum  = {1'b0, row} + {1'b0, b};
    prow = (sum >= (ROW_WIDTH+1)'(V_TILES)) ? sum - (ROW_WIDTH+1)'(V_TILES) : sum;
    ok   = ({1'b0, row} < (ROW_WIDTH+1)'(V_TILES)) &&
           ({1'b0, col} < (COL_WIDTH+1)'(WORDS_PER_ROW));
    addr = ADDR_WIDTH'(prow) * ADDR_WIDTH'(WORDS_PER_ROW) + ADDR_WIDTH'(col);
    return {ok, addr};
  endfunction

  logic [ADDR_WIDTH:0] w_map, r_map, v_map;

  assign w_map = map_addr(w_row_i, w_col_i, base);
  assign r_map = map_addr(r_row_i, r_col_i, base);
  assign v_map = map_addr(vr_row_i, vr_col_i, base);

  assign scroll_row_o = base;

  // Clear-engine / scroll FSM. busy_o is registered alongside the state so
  // it is high exactly while the state is not IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      base    <= '0;
      clr_row <= '0;
      cnt     <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req_i) begin
            // Clear-all wins; a coincident scroll is dropped.
            state  <= CLR_ALL;
            cnt    <= '0;
            base   <= '0;
            busy_o <= 1'b1;
          end else if (scroll_i) begin
            // The old top row becomes the new logical bottom row.
            state   <= CLR_ROW;
            cnt     <= '0;
            clr_row <= base;
            base    <= (base == LAST_ROW) ? '0 : base + 1'b1;
            busy_o  <= 1'b1;
          end
        end
        CLR_ROW: begin
          if (cnt == ROW_LAST_W) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLR_ALL: begin
          if (cnt == ALL_LAST_W) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Single memory write port shared between the clear engine and AXI writes.
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [CHARS_PER_WORD-1:0] mem_wmask;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    case (state)
      CLR_ROW: begin
        mem_we    = 1'b1;
        mem_waddr = ADDR_WIDTH'(clr_row) * ADDR_WIDTH'(WORDS_PER_ROW) + cnt;
        mem_wdata = CLEAR_WORD;
        mem_wmask = '1;
      end
      CLR_ALL: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = CLEAR_WORD;
        mem_wmask = '1;
      end
      default: begin
        if (wr_en_i && w_map[ADDR_WIDTH]) begin
          mem_we    = 1'b1;
          mem_waddr = w_map[ADDR_WIDTH-1:0];
          mem_wdata = din_i;
          mem_wmask = w_strb_i;
        end
      end
    endcase
  end

  // Per-character write enables; reset gates the write so an aborted clear
  // leaves the word in flight untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      for (int k = 0; k < CHARS_PER_WORD; k++) begin
        if (mem_wmask[k]) begin
          mem[mem_waddr][k*CHAR_WIDTH +: CHAR_WIDTH] <= mem_wdata[k*CHAR_WIDTH +: CHAR_WIDTH];
        end
      end
    end
  end

  // Read ports: read-before-write against the write port above.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_o   <= '0;
      r_data_o <= '0;
    end else begin
      dout_o <= v_map[ADDR_WIDTH] ? mem[v_map[ADDR_WIDTH-1:0]] : '0;
      if (r_req_i) begin
        r_data_o <= r_map[ADDR_WIDTH] ? mem[r_map[ADDR_WIDTH-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_buffer.sv
module tb_vga_tile_buffer;

  localparam int VT = 30;
  localparam int WPR = 20;
  localparam int NW = 600;
  localparam logic [27:0] CLRW = 28'h4081020;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [4:0]  w_row_i, w_col_i;
  logic [3:0]  w_strb_i;
  logic [27:0] din_i;
  logic        r_req_i;
  logic [4:0]  r_row_i, r_col_i;
  logic [27:0] r_data_o;
  logic [4:0]  vr_row_i, vr_col_i;
  logic [27:0] dout_o;
  logic        scroll_i, clr_req_i;
  logic        busy_o;
  logic [4:0]  scroll_row_o;

  vga_tile_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .w_row_i(w_row_i), .w_col_i(w_col_i),
    .w_strb_i(w_strb_i), .din_i(din_i),
    .r_req_i(r_req_i), .r_row_i(r_row_i), .r_col_i(r_col_i), .r_data_o(r_data_o),
    .vr_row_i(vr_row_i), .vr_col_i(vr_col_i), .dout_o(dout_o),
    .scroll_i(scroll_i), .clr_req_i(clr_req_i),
    .busy_o(busy_o), .scroll_row_o(scroll_row_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [27:0] m_mem [NW];
  int          m_base = 0;
  int          clr_q[$];
  logic [27:0] exp_dout  = '0;
  logic [27:0] exp_rdata = '0;
  bit          exp_busy  = 1'b0;

  initial for (int i = 0; i < NW; i++) m_mem[i] = '0;

  function automatic int phys(input int row, input int col);
    return ((row + m_base) % VT) * WPR + col;
  endfunction

  function automatic logic [27:0] m_read(input int row, input int col);
    if (row >= VT || col >= WPR) return '0;
    return m_mem[phys(row, col)];
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      exp_dout  = '0;
      exp_rdata = '0;
      clr_q.delete();
      m_base    = 0;
    end else begin
      exp_dout = m_read(int'(vr_row_i), int'(vr_col_i));
      if (r_req_i) exp_rdata = m_read(int'(r_row_i), int'(r_col_i));
      if (clr_q.size() != 0) begin
        m_mem[clr_q.pop_front()] = CLRW;
      end else begin
        if (wr_en_i && int'(w_row_i) < VT && int'(w_col_i) < WPR) begin
          int a;
          a = phys(int'(w_row_i), int'(w_col_i));
          for (int k = 0; k < 4; k++)
            if (w_strb_i[k]) m_mem[a][k*7 +: 7] = din_i[k*7 +: 7];
        end
        if (clr_req_i) begin
          for (int i = 0; i < NW; i++) clr_q.push_back(i);
          m_base = 0;
        end else if (scroll_i) begin
          for (int c = 0; c < WPR; c++) clr_q.push_back(m_base * WPR + c);
          m_base = (m_base + 1) % VT;
        end
      end
    end
    exp_busy = (clr_q.size() != 0);
  end

  always @(negedge clk_i) begin
    if (check_en) begin
      check("dout", 32'(dout_o), 32'(exp_dout));
      check("r_data", 32'(r_data_o), 32'(exp_rdata));
      check("busy", 32'(busy_o), 32'(exp_busy));
      check("scroll_row", 32'(scroll_row_o), m_base);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wr(input int row, input int col, input logic [3:0] strb, input logic [27:0] d);
    wr_en_i = 1'b1; w_row_i = 5'(row); w_col_i = 5'(col); w_strb_i = strb; din_i = d;
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic rd(input int row, input int col, output logic [27:0] d);
    r_req_i = 1'b1; r_row_i = 5'(row); r_col_i = 5'(col);
    step();
    r_req_i = 1'b0;
    d = r_data_o;
  endtask

  // Pulse scroll, return number of busy cycles observed (bounded).
  task automatic do_scroll(output int busy_cnt);
    scroll_i = 1'b1;
    step();
    scroll_i = 1'b0;
    busy_cnt = 0;
    while (busy_o && busy_cnt < 2000) begin
      busy_cnt++;
      step();
    end
  endtask

  logic [27:0] d;
  int          bc;

  initial begin
    rst_i = 1'b1; wr_en_i = 0; w_row_i = 0; w_col_i = 0; w_strb_i = 0; din_i = 0;
    r_req_i = 0; r_row_i = 0; r_col_i = 0; vr_row_i = 0; vr_col_i = 0;
    scroll_i = 0; clr_req_i = 0;
    repeat (3) step();
    check("reset_dout", 32'(dout_o), 0);
    check("reset_rdata", 32'(r_data_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_scroll", 32'(scroll_row_o), 0);
    rst_i = 1'b0;

    // bring every word to a known zero state
    for (int i = 0; i < NW; i++) wr(i / WPR, i % WPR, 4'hF, 28'h0);
    repeat (2) step();
    check_en = 1'b1;

    // strobed write
    wr(2, 3, 4'b0101, 28'hFFFFFFF);
    rd(2, 3, d);
    check("strobe_write", 32'(d), 32'h01FC07F);

    // read-before-write on the same address
    wr_en_i = 1'b1; w_row_i = 2; w_col_i = 3; w_strb_i = 4'hF; din_i = 28'h0ABCDEF;
    r_req_i = 1'b1; r_row_i = 2; r_col_i = 3;
    step();
    wr_en_i = 1'b0; r_req_i = 1'b0;
    check("rbw_old", 32'(r_data_o), 32'h01FC07F);
    rd(2, 3, d);
    check("rbw_new", 32'(d), 32'h0ABCDEF);

    // scroll
    for (int c = 0; c < WPR; c++) wr(0, c, 4'hF, {4{7'h41}});
    wr(1, 0, 4'hF, 28'h1234567);
    scroll_i = 1'b1;
    step();
    scroll_i = 1'b0;
    check("scroll_row_1", 32'(scroll_row_o), 1);
    bc = 0;
    while (busy_o && bc < 2000) begin bc++; step(); end
    check("scroll_busy_len", bc, 20);
    rd(29, 0, d);  check("bottom_cleared0", 32'(d), 32'(CLRW));
    rd(29, 19, d); check("bottom_cleared19", 32'(d), 32'(CLRW));
    rd(0, 0, d);   check("row0_is_old_row1", 32'(d), 32'h1234567);

    // wrap-around, each scroll issued in the cycle busy falls
    for (int i = 0; i < 29; i++) do_scroll(bc);
    check("wrap_busy_len", bc, 20);
    check("wrap_scroll_row", 32'(scroll_row_o), 0);
    wr(0, 7, 4'hF, 28'h7654321);
    rd(0, 7, d); check("wrap_row0_map", 32'(d), 32'h7654321);

    // clear-all with simultaneous scroll, base = 5
    for (int i = 0; i < 5; i++) do_scroll(bc);
    check("base_5", 32'(scroll_row_o), 5);
    clr_req_i = 1'b1; scroll_i = 1'b1;
    step();
    clr_req_i = 1'b0; scroll_i = 1'b0;
    check("clr_scroll_row0", 32'(scroll_row_o), 0);
    bc = 0;
    while (busy_o && bc < 2000) begin
      bc++;
      wr_en_i = (bc % 50 == 0); w_row_i = 0; w_col_i = 0; w_strb_i = 4'hF; din_i = 28'h3333333;
      step();
    end
    wr_en_i = 1'b0;
    check("clrall_busy_len", bc, 600);
    check("clrall_scroll_row", 32'(scroll_row_o), 0);
    rd(0, 0, d);   check("clrall_word0", 32'(d), 32'(CLRW));
    rd(29, 19, d); check("clrall_word599", 32'(d), 32'(CLRW));

    // reset mid-clear at clear cycle 100
    wr(4, 19, 4'hF, 28'h5555555);
    wr(5, 0, 4'hF, 28'h5555555);
    clr_req_i = 1'b1;
    step();
    clr_req_i = 1'b0;
    repeat (100) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_scroll", 32'(scroll_row_o), 0);
    rd(4, 19, d); check("midrst_word99", 32'(d), 32'(CLRW));
    rd(5, 0, d);  check("midrst_word100", 32'(d), 32'h5555555);

    // out-of-range
    wr(30, 0, 4'hF, 28'h7777777);
    wr(0, 20, 4'hF, 28'h7777777);
    wr(31, 31, 4'hF, 28'h7777777);
    rd(30, 0, d); check("oor_row_read", 32'(d), 0);
    rd(0, 20, d); check("oor_col_read", 32'(d), 0);
    rd(0, 0, d);  check("oor_no_write", 32'(d), 32'(CLRW));
    vr_row_i = 30; vr_col_i = 0;
    step(); step();
    check("oor_display", 32'(dout_o), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en_i   = ($urandom_range(0, 2) == 0);
      w_row_i   = 5'($urandom_range(0, 31));
      w_col_i   = 5'($urandom_range(0, 23));
      w_strb_i  = 4'($urandom_range(0, 15));
      din_i     = 28'($urandom);
      r_req_i   = ($urandom_range(0, 1) == 0);
      r_row_i   = 5'($urandom_range(0, 31));
      r_col_i   = 5'($urandom_range(0, 23));
      vr_row_i  = 5'($urandom_range(0, 31));
      vr_col_i  = 5'($urandom_range(0, 23));
      scroll_i  = ($urandom_range(0, 99) == 0);
      clr_req_i = ($urandom_range(0, 1499) == 0);
      step();
    end
    wr_en_i = 0; r_req_i = 0; scroll_i = 0; clr_req_i = 0;
    bc = 0;
    while (busy_o && bc < 2000) begin bc++; step(); end
    check("final_idle", 32'(busy_o), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
